// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit framer: state encoding, header layout
// and byte-enable codes.
package udp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR0    = 3'd1,
      ST_HDR1    = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_DRAIN   = 3'd4
   } udp_state_t;

   localparam logic [15:0] UDP_HDR_LEN = 16'd8;

   // Bit offsets of the 16-bit fields inside the two header words.
   localparam int SRC_PORT_LSB = 16;
   localparam int DST_PORT_LSB = 0;
   localparam int UDP_LEN_LSB  = 16;
   localparam int CSUM_LSB     = 0;

   localparam logic [3:0] BE_4 = 4'b1111;
   localparam logic [3:0] BE_3 = 4'b1110;
   localparam logic [3:0] BE_2 = 4'b1100;
   localparam logic [3:0] BE_1 = 4'b1000;

   // Byte-enable code covering the first n bytes of a word, saturating at 4.
   function automatic logic [3:0] be_from_count(input logic [15:0] n);
      if (n >= 16'd4)      return BE_4;
      else if (n == 16'd3) return BE_3;
      else if (n == 16'd2) return BE_2;
      else                 return BE_1;
   endfunction

endpackage

// File: rtl/udp_be_count.sv
// Maps a legal byte-enable code (1111/1110/1100/1000) to its byte count 1..4.
module udp_be_count
   import udp_pkg::*;
(
   input  logic [3:0] be,
   output logic [2:0] count
);

   always_comb begin
      case (be)
         BE_4:    count = 3'd4;
         BE_3:    count = 3'd3;
         BE_2:    count = 3'd2;
         default: count = 3'd1;
      endcase
   end

endmodule

// File: rtl/udp_tx.sv
// UDP transmit framer: prepends the 8-byte UDP header to a 32-bit user stream.
// Optional payload length enforcement is enabled with UDP_TX_LEN_CHECK_EN.
module udp_tx
   import udp_pkg::*;
#(
   parameter int          MAX_PAYLOAD = 1472,
   parameter logic [15:0] CSUM_VAL    = 16'h0000
) (
   input  logic        clk_user_i,
   input  logic        reset_i,
   input  logic        tx_usr_start_i,
   input  logic [15:0] tx_usr_len_i,
   input  logic [15:0] tx_usr_dst_port_i,
   input  logic [31:0] tx_usr_dst_ip_i,
   output logic        tx_usr_busy_o,
   input  logic        tx_usr_data_vld_i,
   input  logic [31:0] tx_usr_data_i,
   input  logic [3:0]  tx_usr_be_i,
   input  logic        tx_usr_tlast_i,
   output logic        tx_usr_ready_o,
   output logic        tx_ip_data_vld_o,
   output logic [31:0] tx_ip_data_o,
   output logic [3:0]  tx_ip_be_o,
   output logic        tx_ip_tlast_o,
   input  logic        tx_ip_ready_i,
   output logic [15:0] tx_ip_len_o,
   output logic [31:0] tx_ip_dst_ip_o,
   output logic        tx_err_o,
   input  logic [15:0] our_port_i
);

   localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

   udp_state_t  state_reg, state_next;
   logic [15:0] len_reg, len_next;
   logic [15:0] port_reg, port_next;
   logic [31:0] ip_reg, ip_next;
   logic [15:0] ip_len_reg, ip_len_next;
   logic        vld_reg, vld_next;
   logic [31:0] data_reg, data_next;
   logic [3:0]  be_reg, be_next;
   logic        tlast_reg, tlast_next;
   logic        busy_reg, busy_next;
   logic        err_reg, err_next;
   logic        ready;
   logic        ld;
   logic        last_pend;

   assign ld        = !vld_reg | tx_ip_ready_i;
   assign last_pend = vld_reg & tlast_reg;

`ifdef UDP_TX_LEN_CHECK_EN
   logic [15:0] cnt_reg, cnt_next;
   logic        tail_reg, tail_next;
   logic [2:0]  word_bytes;
   logic [15:0] cnt_sum;
   logic [15:0] rem;

   // Non-final words always carry four bytes regardless of tx_usr_be_i.
   udp_be_count u_be_count (
      .be    (tx_usr_tlast_i ? tx_usr_be_i : BE_4),
      .count (word_bytes)
   );

   assign cnt_sum = cnt_reg + {13'd0, word_bytes};
   assign rem     = len_reg - cnt_reg;
`endif

   always_comb begin
      state_next  = state_reg;
      len_next    = len_reg;
      port_next   = port_reg;
      ip_next     = ip_reg;
      ip_len_next = ip_len_reg;
      vld_next    = vld_reg & !tx_ip_ready_i;
      data_next   = data_reg;
      be_next     = be_reg;
      tlast_next  = tlast_reg & vld_next;
      err_next    = 1'b0;
      ready       = 1'b0;
`ifdef UDP_TX_LEN_CHECK_EN
      cnt_next    = cnt_reg;
      tail_next   = tail_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (tx_usr_start_i) begin
               if (tx_usr_len_i > MAX_LEN) begin
                  err_next = 1'b1;
               end else begin
                  len_next    = tx_usr_len_i;
                  port_next   = tx_usr_dst_port_i;
                  ip_next     = tx_usr_dst_ip_i;
                  ip_len_next = tx_usr_len_i + UDP_HDR_LEN;
                  state_next  = ST_HDR0;
`ifdef UDP_TX_LEN_CHECK_EN
                  cnt_next    = 16'd0;
                  tail_next   = 1'b0;
`endif
               end
            end
         end
         ST_HDR0: begin
            if (ld) begin
               vld_next                        = 1'b1;
               data_next[SRC_PORT_LSB +: 16]   = our_port_i;
               data_next[DST_PORT_LSB +: 16]   = port_reg;
               be_next                         = BE_4;
               tlast_next                      = 1'b0;
               state_next                      = ST_HDR1;
            end
         end
         ST_HDR1: begin
            // An empty datagram ends on word1; stay here until it is taken.
            if (last_pend) begin
               if (tx_ip_ready_i) state_next = ST_IDLE;
            end else if (ld) begin
               vld_next                      = 1'b1;
               data_next[UDP_LEN_LSB +: 16]  = ip_len_reg;
               data_next[CSUM_LSB +: 16]     = CSUM_VAL;
               be_next                       = BE_4;
               tlast_next                    = (len_reg == 16'd0);
               if (len_reg != 16'd0) state_next = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (last_pend) begin
               if (tx_ip_ready_i) state_next = ST_IDLE;
            end else begin
               ready = ld;
               if (tx_usr_data_vld_i && ld) begin
                  vld_next   = 1'b1;
                  data_next  = tx_usr_data_i;
                  be_next    = tx_usr_tlast_i ? tx_usr_be_i : BE_4;
                  tlast_next = tx_usr_tlast_i;
`ifdef UDP_TX_LEN_CHECK_EN
                  cnt_next = cnt_sum;
                  if (cnt_sum >= len_reg) begin
                     be_next    = be_from_count(rem);
                     tlast_next = 1'b1;
                     if (!tx_usr_tlast_i) begin
                        err_next   = 1'b1;
                        state_next = ST_DRAIN;
                     end
                  end
                  if (tx_usr_tlast_i && (cnt_sum != len_reg)) err_next = 1'b1;
`endif
               end
            end
         end
         ST_DRAIN: begin
`ifdef UDP_TX_LEN_CHECK_EN
            // Discard the user's surplus words while the truncated last word drains.
            ready = !tail_reg;
            if (tx_usr_data_vld_i && !tail_reg && tx_usr_tlast_i) tail_next = 1'b1;
            if (tail_next && !vld_next) state_next = ST_IDLE;
`else
            state_next = ST_IDLE;
`endif
         end
         default: state_next = ST_IDLE;
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   always_ff @(posedge clk_user_i) begin
      if (reset_i) begin
         state_reg  <= ST_IDLE;
         len_reg    <= '0;
         port_reg   <= '0;
         ip_reg     <= '0;
         ip_len_reg <= '0;
         vld_reg    <= 1'b0;
         data_reg   <= '0;
         be_reg     <= '0;
         tlast_reg  <= 1'b0;
         busy_reg   <= 1'b0;
         err_reg    <= 1'b0;
`ifdef UDP_TX_LEN_CHECK_EN
         cnt_reg    <= '0;
         tail_reg   <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         len_reg    <= len_next;
         port_reg   <= port_next;
         ip_reg     <= ip_next;
         ip_len_reg <= ip_len_next;
         vld_reg    <= vld_next;
         data_reg   <= data_next;
         be_reg     <= be_next;
         tlast_reg  <= tlast_next;
         busy_reg   <= busy_next;
         err_reg    <= err_next;
`ifdef UDP_TX_LEN_CHECK_EN
         cnt_reg    <= cnt_next;
         tail_reg   <= tail_next;
`endif
      end
   end

   assign tx_usr_busy_o    = busy_reg;
   assign tx_usr_ready_o   = ready;
   assign tx_ip_data_vld_o = vld_reg;
   assign tx_ip_data_o     = data_reg;
   assign tx_ip_be_o       = be_reg;
   assign tx_ip_tlast_o    = tlast_reg;
   assign tx_ip_len_o      = ip_len_reg;
   assign tx_ip_dst_ip_o   = ip_reg;
   assign tx_err_o         = err_reg;

endmodule

// File: tb/tb_udp_tx.sv
// Directed bench for udp_tx: header framing, byte enables, back-pressure,
// oversize rejection, reset mid-frame and (with UDP_TX_LEN_CHECK_EN) truncation.
module tb_udp_tx;

   logic        clk_user_i = 1'b0;
   logic        reset_i;
   logic        tx_usr_start_i;
   logic [15:0] tx_usr_len_i;
   logic [15:0] tx_usr_dst_port_i;
   logic [31:0] tx_usr_dst_ip_i;
   logic        tx_usr_busy_o;
   logic        tx_usr_data_vld_i;
   logic [31:0] tx_usr_data_i;
   logic [3:0]  tx_usr_be_i;
   logic        tx_usr_tlast_i;
   logic        tx_usr_ready_o;
   logic        tx_ip_data_vld_o;
   logic [31:0] tx_ip_data_o;
   logic [3:0]  tx_ip_be_o;
   logic        tx_ip_tlast_o;
   logic        tx_ip_ready_i;
   logic [15:0] tx_ip_len_o;
   logic [31:0] tx_ip_dst_ip_o;
   logic        tx_err_o;
   logic [15:0] our_port_i;

   always #5 clk_user_i = ~clk_user_i;

   udp_tx dut (
      .clk_user_i        (clk_user_i),
      .reset_i           (reset_i),
      .tx_usr_start_i    (tx_usr_start_i),
      .tx_usr_len_i      (tx_usr_len_i),
      .tx_usr_dst_port_i (tx_usr_dst_port_i),
      .tx_usr_dst_ip_i   (tx_usr_dst_ip_i),
      .tx_usr_busy_o     (tx_usr_busy_o),
      .tx_usr_data_vld_i (tx_usr_data_vld_i),
      .tx_usr_data_i     (tx_usr_data_i),
      .tx_usr_be_i       (tx_usr_be_i),
      .tx_usr_tlast_i    (tx_usr_tlast_i),
      .tx_usr_ready_o    (tx_usr_ready_o),
      .tx_ip_data_vld_o  (tx_ip_data_vld_o),
      .tx_ip_data_o      (tx_ip_data_o),
      .tx_ip_be_o        (tx_ip_be_o),
      .tx_ip_tlast_o     (tx_ip_tlast_o),
      .tx_ip_ready_i     (tx_ip_ready_i),
      .tx_ip_len_o       (tx_ip_len_o),
      .tx_ip_dst_ip_o    (tx_ip_dst_ip_o),
      .tx_err_o          (tx_err_o),
      .our_port_i        (our_port_i)
   );

   int vectors     = 0;
   int miscompares = 0;
   int err_cnt     = 0;
   logic [36:0] out_q[$];
   logic [36:0] exp_q[$];

   // Inputs change only just after posedge, so a negedge sample shows what the next edge takes.
   always @(negedge clk_user_i) begin
      if (!reset_i && tx_ip_data_vld_o && tx_ip_ready_i)
         out_q.push_back({tx_ip_tlast_o, tx_ip_be_o, tx_ip_data_o});
      if (tx_err_o) err_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [36:0] w(input logic [31:0] d, input logic [3:0] b, input logic t);
      return {t, b, d};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_frame(input string tag);
      logic [36:0] o;
      chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         o = (i < out_q.size()) ? out_q[i] : 'x;
         chk($sformatf("%s_w%0d", tag, i), 64'(o), 64'(exp_q[i]));
      end
      out_q.delete();
      exp_q.delete();
   endtask

   task automatic start_frame(input logic [15:0] len, input logic [15:0] port, input logic [31:0] ip);
      for (int i = 0; i < 200 && tx_usr_busy_o; i++) begin
         @(posedge clk_user_i); #1;
      end
      if (tx_usr_busy_o) chk("start_wait_busy", 64'(tx_usr_busy_o), 64'(0));
      tx_usr_start_i    = 1'b1;
      tx_usr_len_i      = len;
      tx_usr_dst_port_i = port;
      tx_usr_dst_ip_i   = ip;
      @(posedge clk_user_i); #1;
      tx_usr_start_i    = 1'b0;
   endtask

   task automatic push_words(input int n, input logic [31:0] base, input logic [3:0] last_be,
                             input logic with_last);
      logic accepted;
      for (int i = 0; i < n; i++) begin
         tx_usr_data_vld_i = 1'b1;
         tx_usr_data_i     = base + 32'(i);
         tx_usr_tlast_i    = with_last && (i == n - 1);
         tx_usr_be_i       = (with_last && (i == n - 1)) ? last_be : 4'hF;
         accepted          = 1'b0;
         for (int c = 0; c < 100; c++) begin
            @(negedge clk_user_i);
            if (tx_usr_ready_o) begin
               accepted = 1'b1;
               break;
            end
         end
         @(posedge clk_user_i); #1;
         if (!accepted) chk("push_accept", 64'(accepted), 64'(1));
      end
      tx_usr_data_vld_i = 1'b0;
      tx_usr_tlast_i    = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && tx_usr_busy_o; i++) begin
         @(posedge clk_user_i); #1;
      end
      chk("idle_wait", 64'(tx_usr_busy_o), 64'(0));
   endtask

   initial begin
      int e0;
      bit seen;
      reset_i           = 1'b1;
      tx_usr_start_i    = 1'b0;
      tx_usr_len_i      = '0;
      tx_usr_dst_port_i = '0;
      tx_usr_dst_ip_i   = '0;
      tx_usr_data_vld_i = 1'b0;
      tx_usr_data_i     = '0;
      tx_usr_be_i       = '0;
      tx_usr_tlast_i    = 1'b0;
      tx_ip_ready_i     = 1'b1;
      our_port_i        = 16'h0400;
      repeat (3) @(posedge clk_user_i);
      #1;
      chk("rst_vld",   64'(tx_ip_data_vld_o), 64'(0));
      chk("rst_busy",  64'(tx_usr_busy_o),    64'(0));
      chk("rst_ready", 64'(tx_usr_ready_o),   64'(0));
      chk("rst_err",   64'(tx_err_o),         64'(0));
      chk("rst_data",  64'({tx_ip_tlast_o, tx_ip_be_o, tx_ip_data_o}), 64'(0));
      chk("rst_len",   64'(tx_ip_len_o),      64'(0));
      chk("rst_ip",    64'(tx_ip_dst_ip_o),   64'(0));
      reset_i = 1'b0;
      @(posedge clk_user_i); #1;

      // len=8, two full words
      start_frame(16'd8, 16'h1234, 32'hC0A80001);
      chk("f8_busy", 64'(tx_usr_busy_o), 64'(1));
      chk("f8_len",  64'(tx_ip_len_o),   64'(16));
      chk("f8_ip",   64'(tx_ip_dst_ip_o), 64'(32'hC0A80001));
      push_words(2, 32'h11110000, 4'hF, 1'b1);
      wait_idle();
      exp_q.push_back(w(32'h04001234, 4'hF, 1'b0));
      exp_q.push_back(w(32'h00100000, 4'hF, 1'b0));
      exp_q.push_back(w(32'h11110000, 4'hF, 1'b0));
      exp_q.push_back(w(32'h11110001, 4'hF, 1'b1));
      chk_frame("f8");

      // len=5, partial last word
      start_frame(16'd5, 16'h0035, 32'h0A000002);
      chk("f5_len", 64'(tx_ip_len_o), 64'(13));
      push_words(2, 32'hAABB0000, 4'h8, 1'b1);
      wait_idle();
      exp_q.push_back(w(32'h04000035, 4'hF, 1'b0));
      exp_q.push_back(w(32'h000D0000, 4'hF, 1'b0));
      exp_q.push_back(w(32'hAABB0000, 4'hF, 1'b0));
      exp_q.push_back(w(32'hAABB0001, 4'h8, 1'b1));
      chk_frame("f5");

      // len=0: header only, busy drops right after the last accept, restart in that cycle
      start_frame(16'd0, 16'h0007, 32'h01020304);
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_user_i);
         if (tx_ip_data_vld_o && tx_ip_tlast_o) begin
            seen = 1'b1;
            break;
         end
      end
      chk("f0_last_seen", 64'(seen), 64'(1));
      chk("f0_busy_last", 64'(tx_usr_busy_o), 64'(1));
      @(posedge clk_user_i); #1;
      chk("f0_busy_drop", 64'(tx_usr_busy_o), 64'(0));
      tx_usr_start_i    = 1'b1;
      tx_usr_len_i      = 16'd0;
      tx_usr_dst_port_i = 16'h0008;
      @(posedge clk_user_i); #1;
      tx_usr_start_i    = 1'b0;
      chk("f0_restart_busy", 64'(tx_usr_busy_o), 64'(1));
      wait_idle();
      exp_q.push_back(w(32'h04000007, 4'hF, 1'b0));
      exp_q.push_back(w(32'h00080000, 4'hF, 1'b1));
      exp_q.push_back(w(32'h04000008, 4'hF, 1'b0));
      exp_q.push_back(w(32'h00080000, 4'hF, 1'b1));
      chk_frame("f0");

      // back-pressure for 3 cycles while payload word D1 is on the output
      start_frame(16'd12, 16'h0050, 32'h0A0A0A0A);
      fork
         push_words(3, 32'h33330000, 4'hF, 1'b1);
         begin
            repeat (4) @(posedge clk_user_i);
            #1 tx_ip_ready_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk_user_i);
               chk($sformatf("stall_data%0d", k), 64'(tx_ip_data_o), 64'(32'h33330001));
               chk($sformatf("stall_vld%0d", k),  64'(tx_ip_data_vld_o), 64'(1));
               chk($sformatf("stall_rdy%0d", k),  64'(tx_usr_ready_o), 64'(0));
            end
            @(posedge clk_user_i);
            #1 tx_ip_ready_i = 1'b1;
         end
      join
      wait_idle();
      exp_q.push_back(w(32'h04000050, 4'hF, 1'b0));
      exp_q.push_back(w(32'h00140000, 4'hF, 1'b0));
      exp_q.push_back(w(32'h33330000, 4'hF, 1'b0));
      exp_q.push_back(w(32'h33330001, 4'hF, 1'b0));
      exp_q.push_back(w(32'h33330002, 4'hF, 1'b1));
      chk_frame("stall");

      // oversize request
      e0 = err_cnt;
      start_frame(16'd2000, 16'h0077, 32'h0C0C0C0C);
      chk("big_err",  64'(tx_err_o),      64'(1));
      chk("big_busy", 64'(tx_usr_busy_o), 64'(0));
      @(posedge clk_user_i); #1;
      chk("big_err_drop", 64'(tx_err_o), 64'(0));
      repeat (4) @(posedge clk_user_i);
      #1;
      chk("big_busy_after", 64'(tx_usr_busy_o), 64'(0));
      chk("big_err_pulses", 64'(err_cnt - e0), 64'(1));
      chk_frame("big");

`ifdef UDP_TX_LEN_CHECK_EN
      // length check: len=4 but the user sends three words
      e0 = err_cnt;
      start_frame(16'd4, 16'h0099, 32'h0D0D0D0D);
      push_words(3, 32'h44440000, 4'hF, 1'b1);
      wait_idle();
      chk("trunc_err_pulses", 64'(err_cnt - e0), 64'(1));
      exp_q.push_back(w(32'h04000099, 4'hF, 1'b0));
      exp_q.push_back(w(32'h000C0000, 4'hF, 1'b0));
      exp_q.push_back(w(32'h44440000, 4'hF, 1'b1));
      chk_frame("trunc");
`endif

      // reset in the middle of a payload
      start_frame(16'd16, 16'h0011, 32'h0E0E0E0E);
      push_words(2, 32'h55550000, 4'hF, 1'b0);
      reset_i = 1'b1;
      @(posedge clk_user_i); #1;
      chk("mrst_vld",   64'(tx_ip_data_vld_o), 64'(0));
      chk("mrst_busy",  64'(tx_usr_busy_o),    64'(0));
      chk("mrst_ready", 64'(tx_usr_ready_o),   64'(0));
      chk("mrst_data",  64'({tx_ip_tlast_o, tx_ip_be_o, tx_ip_data_o}), 64'(0));
      chk("mrst_len",   64'(tx_ip_len_o),      64'(0));
      chk("mrst_ip",    64'(tx_ip_dst_ip_o),   64'(0));
      reset_i = 1'b0;
      out_q.delete();
      @(posedge clk_user_i); #1;
      start_frame(16'd4, 16'h0022, 32'h0B0B0B0B);
      chk("post_len", 64'(tx_ip_len_o), 64'(12));
      push_words(1, 32'h66660000, 4'hF, 1'b1);
      wait_idle();
      exp_q.push_back(w(32'h04000022, 4'hF, 1'b0));
      exp_q.push_back(w(32'h000C0000, 4'hF, 1'b0));
      exp_q.push_back(w(32'h66660000, 4'hF, 1'b1));
      chk_frame("post");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
